// File: rtl/alu.sv
// alu: 32-bit single-transaction ALU with acknowledged write-back routing.
// Optional feature macro: ALU_MUL_EN (enables MUL as low 32 bits of A*B;
// without it MUL behaves as a reserved op and no multiplier is built).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   op_code, input_A, input_B  operation and operands
//   reg_out, reg_addr          route result to register file / destination reg
//   mem_out, mem_addr          route result to memory / destination address
//   pc_jump                    route result to PC
//   inputs_valid               operands and routing valid (sampled in IDLE)
//   reg_wr_*                   register write channel (valid/ack handshake)
//   mem_wr_*                   memory write channel (valid/ack handshake)
//   pc_branch_data*            PC branch channel (valid/ack handshake)
//   done                       one-cycle pulse when the transaction completes
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op_code,
  input  logic [31:0] input_A,
  input  logic [31:0] input_B,
  input  logic        reg_out,
  input  logic [4:0]  reg_addr,
  input  logic        mem_out,
  input  logic [31:0] mem_addr,
  input  logic        pc_jump,
  input  logic        inputs_valid,
  output logic [31:0] reg_wr_data,
  output logic [4:0]  reg_wr_addr,
  output logic        reg_wr_data_valid,
  input  logic        reg_wr_ack,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mem_wr_addr,
  output logic        mem_wr_data_valid,
  input  logic        mem_wr_ack,
  output logic [31:0] pc_branch_data,
  output logic        pc_branch_data_valid,
  input  logic        pc_branch_data_ack,
  output logic        done
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9,
    MUL  = 4'd10
  } ALU_OP_CODE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_e;

  ALU_OP_CODE         op_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic [DATA_W-1:0]  result_c;

  state_e             state_q,  state_d;
  logic [DATA_W-1:0]  data_q,   data_d;
  logic [RADDR_W-1:0] raddr_q,  raddr_d;
  logic [DATA_W-1:0]  maddr_q,  maddr_d;
  logic               rv_q,     rv_d;
  logic               mv_q,     mv_d;
  logic               pv_q,     pv_d;
  logic               done_q,   done_d;

  assign op_c    = ALU_OP_CODE'(op_code);
  assign shamt_c = input_B[SHAMT_W-1:0];

  // Combinational result; all arithmetic wraps at 32 bits.
  always_comb begin
    result_c = '0;
    case (op_c)
      ADD:  result_c = input_A + input_B;
      SUB:  result_c = input_A - input_B;
      AND:  result_c = input_A & input_B;
      OR:   result_c = input_A | input_B;
      XOR:  result_c = input_A ^ input_B;
      SLL:  result_c = input_A << shamt_c;
      SRL:  result_c = input_A >> shamt_c;
      SRA:  result_c = DATA_W'($signed(input_A) >>> shamt_c);
      SLT:  result_c = DATA_W'($signed(input_A) < $signed(input_B));
      SLTU: result_c = DATA_W'(input_A < input_B);
`ifdef ALU_MUL_EN
      MUL:  result_c = input_A * input_B;
`else
      MUL:  result_c = '0;
`endif
      default: result_c = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    raddr_d = raddr_q;
    maddr_d = maddr_q;
    rv_d    = rv_q;
    mv_d    = mv_q;
    pv_d    = pv_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (inputs_valid) begin
          data_d  = result_c;
          raddr_d = reg_addr;
          maddr_d = mem_addr;
          rv_d    = reg_out;
          mv_d    = mem_out;
          pv_d    = pc_jump;
          // No destination selected: complete immediately.
          if (!(reg_out || mem_out || pc_jump)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        // An ack only matters while its own valid is up.
        rv_d = rv_q & ~reg_wr_ack;
        mv_d = mv_q & ~mem_wr_ack;
        pv_d = pv_q & ~pc_branch_data_ack;
        if (!(rv_d || mv_d || pv_d)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      raddr_q <= '0;
      maddr_q <= '0;
      rv_q    <= 1'b0;
      mv_q    <= 1'b0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      raddr_q <= raddr_d;
      maddr_q <= maddr_d;
      rv_q    <= rv_d;
      mv_q    <= mv_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
    end
  end

  assign reg_wr_data          = data_q;
  assign reg_wr_addr          = raddr_q;
  assign reg_wr_data_valid    = rv_q;
  assign mem_wr_data          = data_q;
  assign mem_wr_addr          = maddr_q;
  assign mem_wr_data_valid    = mv_q;
  assign pc_branch_data       = data_q;
  assign pc_branch_data_valid = pv_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. A transaction-level model predicts
// every output each cycle; directed vectors add literal expectations.
module tb_alu;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_RSV  = 4'd15;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op_code;
  logic [31:0] input_A, input_B;
  logic        reg_out, mem_out, pc_jump, inputs_valid;
  logic [4:0]  reg_addr;
  logic [31:0] mem_addr;
  logic [31:0] reg_wr_data, mem_wr_data, mem_wr_addr, pc_branch_data;
  logic [4:0]  reg_wr_addr;
  logic        reg_wr_data_valid, mem_wr_data_valid, pc_branch_data_valid, done;
  logic        reg_wr_ack, mem_wr_ack, pc_branch_data_ack;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  alu dut (
    .clk(clk), .reset(reset), .op_code(op_code),
    .input_A(input_A), .input_B(input_B),
    .reg_out(reg_out), .reg_addr(reg_addr),
    .mem_out(mem_out), .mem_addr(mem_addr), .pc_jump(pc_jump),
    .inputs_valid(inputs_valid),
    .reg_wr_data(reg_wr_data), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data_valid(reg_wr_data_valid), .reg_wr_ack(reg_wr_ack),
    .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data_valid(mem_wr_data_valid), .mem_wr_ack(mem_wr_ack),
    .pc_branch_data(pc_branch_data),
    .pc_branch_data_valid(pc_branch_data_valid),
    .pc_branch_data_ack(pc_branch_data_ack),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0]  sh;
    longint      sa, sb;
    sh = b[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return 32'(sa >>> sh);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      OP_MUL:  return 32'(64'(a) * 64'(b));
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding transaction, a set of pending
  // destinations, done pulses the cycle after the set empties.
  int          m_mode = 0;   // 0 idle, 1 awaiting acks, 2 completing
  logic [2:0]  m_pend = '0;  // {reg, mem, pc}
  logic        m_done = 1'b0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_raddr = '0;
  logic [31:0] m_maddr = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_pend = '0; m_done = 1'b0;
      m_data = '0; m_raddr = '0; m_maddr = '0;
    end else if (m_mode == 0) begin
      m_done = 1'b0;
      if (inputs_valid) begin
        m_data  = ref_alu(op_code, input_A, input_B);
        m_raddr = reg_addr;
        m_maddr = mem_addr;
        m_pend  = {reg_out, mem_out, pc_jump};
        m_mode  = (m_pend == 3'b000) ? 2 : 1;
        m_done  = (m_pend == 3'b000);
      end
    end else if (m_mode == 1) begin
      m_pend = m_pend & ~{reg_wr_ack, mem_wr_ack, pc_branch_data_ack};
      if (m_pend == 3'b000) begin
        m_done = 1'b1;
        m_mode = 2;
      end
    end else begin
      m_done = 1'b0;
      m_mode = 0;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_reg_valid", 32'(reg_wr_data_valid), 32'(m_pend[2]));
      check("m_mem_valid", 32'(mem_wr_data_valid), 32'(m_pend[1]));
      check("m_pc_valid",  32'(pc_branch_data_valid), 32'(m_pend[0]));
      check("m_done",      32'(done), 32'(m_done));
      check("m_reg_data",  reg_wr_data, m_data);
      check("m_mem_data",  mem_wr_data, m_data);
      check("m_pc_data",   pc_branch_data, m_data);
      check("m_reg_addr",  32'(reg_wr_addr), 32'(m_raddr));
      check("m_mem_addr",  mem_wr_addr, m_maddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one transaction, let it be accepted, then drop inputs_valid.
  task automatic go(input logic [3:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic r, input logic m,
                    input logic p, input logic [4:0] ra,
                    input logic [31:0] ma);
    op_code = op; input_A = a; input_B = b;
    reg_out = r; mem_out = m; pc_jump = p;
    reg_addr = ra; mem_addr = ma;
    inputs_valid = 1'b1;
    step();
    inputs_valid = 1'b0;
    reg_out = 1'b0; mem_out = 1'b0; pc_jump = 1'b0;
  endtask

  // Pulse the given acks {reg,mem,pc} for one edge; expect a done pulse.
  task automatic ack_and_close(input logic [2:0] acks, input string tag);
    {reg_wr_ack, mem_wr_ack, pc_branch_data_ack} = acks;
    step();
    {reg_wr_ack, mem_wr_ack, pc_branch_data_ack} = 3'b000;
    @(negedge clk);
    check({tag, "_done_hi"}, 32'(done), 32'd1);
    check({tag, "_valids_lo"},
          32'({reg_wr_data_valid, mem_wr_data_valid, pc_branch_data_valid}),
          32'd0);
    step();
    @(negedge clk);
    check({tag, "_done_lo"}, 32'(done), 32'd0);
  endtask

  logic [3:0]  t_op  [10];
  logic [31:0] t_a   [10];
  logic [31:0] t_b   [10];
  logic [31:0] t_exp [10];
  logic [31:0] mul_exp;

  initial begin
    t_op[0] = OP_ADD;  t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'd2;          t_exp[0] = 32'd1;
    t_op[1] = OP_SUB;  t_a[1] = 32'd0;         t_b[1] = 32'd1;          t_exp[1] = 32'hFFFF_FFFF;
    t_op[2] = OP_AND;  t_a[2] = 32'hF0F0_F0F0; t_b[2] = 32'hFF00_FF00;  t_exp[2] = 32'hF000_F000;
    t_op[3] = OP_OR;   t_a[3] = 32'hF0F0_F0F0; t_b[3] = 32'h0F00_0000;  t_exp[3] = 32'hFFF0_F0F0;
    t_op[4] = OP_XOR;  t_a[4] = 32'hAAAA_AAAA; t_b[4] = 32'hFFFF_FFFF;  t_exp[4] = 32'h5555_5555;
    t_op[5] = OP_SLL;  t_a[5] = 32'd1;         t_b[5] = 32'h21;         t_exp[5] = 32'd2;
    t_op[6] = OP_SRL;  t_a[6] = 32'h8000_0000; t_b[6] = 32'd31;         t_exp[6] = 32'd1;
    t_op[7] = OP_SLT;  t_a[7] = 32'hFFFF_FFFF; t_b[7] = 32'd1;          t_exp[7] = 32'd1;
    t_op[8] = OP_SLTU; t_a[8] = 32'hFFFF_FFFF; t_b[8] = 32'd1;          t_exp[8] = 32'd0;
    t_op[9] = OP_RSV;  t_a[9] = 32'd5;         t_b[9] = 32'd5;          t_exp[9] = 32'd0;
`ifdef ALU_MUL_EN
    mul_exp = 32'd12;
`else
    mul_exp = 32'd0;
`endif

    reset = 1'b1; op_code = '0; input_A = '0; input_B = '0;
    reg_out = 1'b0; mem_out = 1'b0; pc_jump = 1'b0; inputs_valid = 1'b0;
    reg_addr = '0; mem_addr = '0;
    reg_wr_ack = 1'b0; mem_wr_ack = 1'b0; pc_branch_data_ack = 1'b0;

    // Reset held three cycles.
    step(); chk_en = 1'b1; step(); step();
    @(negedge clk);
    check("rst_valids", 32'({reg_wr_data_valid, mem_wr_data_valid,
                             pc_branch_data_valid}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();

    // ADD 1+1 to register 5; stray acks on idle channels are ignored.
    go(OP_ADD, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 5'd5, 32'd0);
    @(negedge clk);
    check("add_reg_valid", 32'(reg_wr_data_valid), 32'd1);
    check("add_reg_data", reg_wr_data, 32'd2);
    check("add_reg_addr", 32'(reg_wr_addr), 32'd5);
    check("add_reg_done", 32'(done), 32'd0);
    ack_and_close(3'b111, "add_reg");

    // ADD 1+1 to memory address 7.
    go(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd7);
    @(negedge clk);
    check("add_mem_valid", 32'(mem_wr_data_valid), 32'd1);
    check("add_mem_data", mem_wr_data, 32'd2);
    check("add_mem_addr", mem_wr_addr, 32'd7);
    ack_and_close(3'b010, "add_mem");

    // ADD 1+1 to PC only.
    go(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0);
    @(negedge clk);
    check("add_pc_valid", 32'(pc_branch_data_valid), 32'd1);
    check("add_pc_data", pc_branch_data, 32'd2);
    check("add_pc_others", 32'({reg_wr_data_valid, mem_wr_data_valid}), 32'd0);
    ack_and_close(3'b001, "add_pc");

    // SUB 5-7 to reg and mem, acks on different cycles; new inputs ignored.
    go(OP_SUB, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 5'd9, 32'h100);
    @(negedge clk);
    check("sub_reg_data", reg_wr_data, 32'hFFFF_FFFE);
    check("sub_mem_data", mem_wr_data, 32'hFFFF_FFFE);
    input_A = 32'd99; inputs_valid = 1'b1; reg_out = 1'b1;
    reg_wr_ack = 1'b1;
    step();
    reg_wr_ack = 1'b0; inputs_valid = 1'b0; reg_out = 1'b0;
    @(negedge clk);
    check("sub_first_done", 32'(done), 32'd0);
    check("sub_mem_still", 32'(mem_wr_data_valid), 32'd1);
    check("sub_mem_hold", mem_wr_data, 32'hFFFF_FFFE);
    step();
    @(negedge clk);
    check("sub_wait_done", 32'(done), 32'd0);
    ack_and_close(3'b010, "sub_second");

    // Reset while awaiting acks drops the pending writes.
    go(OP_ADD, 32'd2, 32'd3, 1'b1, 1'b0, 1'b1, 5'd3, 32'd0);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("midrst_valids", 32'({reg_wr_data_valid, pc_branch_data_valid}), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_data", reg_wr_data, 32'd0);
    step();
    @(negedge clk);
    check("midrst_hold_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();

    // SRA of the sign bit.
    go(OP_SRA, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0);
    @(negedge clk);
    check("sra_data", pc_branch_data, 32'hF800_0000);
    ack_and_close(3'b001, "sra");

    // MUL 3*4 (12 when the multiplier is built, otherwise 0).
    go(OP_MUL, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 5'd1, 32'd0);
    @(negedge clk);
    check("mul_data", reg_wr_data, mul_exp);
    ack_and_close(3'b100, "mul");

    // No destination: straight to a done pulse.
    go(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("nodest_done", 32'(done), 32'd1);
    check("nodest_valids", 32'({reg_wr_data_valid, mem_wr_data_valid,
                                pc_branch_data_valid}), 32'd0);
    step();
    @(negedge clk);
    check("nodest_done_lo", 32'(done), 32'd0);

    // All three destinations acknowledged together.
    go(OP_XOR, 32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF);
    @(negedge clk);
    check("all3_data", pc_branch_data, 32'h1234_A987);
    check("all3_addr", mem_wr_addr, 32'hDEAD_BEEF);
    ack_and_close(3'b111, "all3");

    // Operation table, each to the register file.
    for (int i = 0; i < 10; i++) begin
      go(t_op[i], t_a[i], t_b[i], 1'b1, 1'b0, 1'b0, 5'(i), 32'd0);
      @(negedge clk);
      check($sformatf("tbl%0d_data", i), reg_wr_data, t_exp[i]);
      ack_and_close(3'b100, $sformatf("tbl%0d", i));
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have no parameters; datapath fixed at 32 bits, op_code is the 4-bit enumerated type ALU_OP_CODE.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: op_code  in  4  operation; input_A  in  32  operand A; input_B  in  32  operand B.
REQ-005 SHALL have ports: reg_out  in  1  route to register file; reg_addr  in  5  destination register.
REQ-006 SHALL have ports: mem_out  in  1  route to memory; mem_addr  in  32  destination address; pc_jump  in  1  route to PC.
REQ-007 SHALL have port: inputs_valid  in  1  operands/routing valid.
REQ-008 SHALL have ports: reg_wr_data  out  32; reg_wr_addr  out  5; reg_wr_data_valid  out  1; reg_wr_ack  in  1.
REQ-009 SHALL have ports: mem_wr_data  out  32; mem_wr_addr  out  32; mem_wr_data_valid  out  1; mem_wr_ack  in  1.
REQ-010 SHALL have ports: pc_branch_data  out  32; pc_branch_data_valid  out  1; pc_branch_data_ack  in  1; done  out  1  transaction complete.

Function
REQ-011 SHALL encode ALU_OP_CODE: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10; 11-15 reserved.
REQ-012 SHALL compute 32-bit results with wrap-around (no carry/overflow out); shifts use input_B[4:0]; SLT signed, SLTU unsigned, result 1 or 0; reserved ops give 0.
REQ-013 SHALL implement FSM states IDLE, WAIT_ACK, DONE; all outputs registered.
REQ-014 SHALL in IDLE, when inputs_valid=1 at a rising edge, register result and addresses and, on that same edge, assert the valid of every selected destination (reg_out, mem_out, pc_jump); enter WAIT_ACK.
REQ-015 SHALL drive reg_wr_data, mem_wr_data and pc_branch_data all with the same result; reg_wr_addr=reg_addr, mem_wr_addr=mem_addr.
REQ-016 SHALL hold each asserted valid and its data/address stable until its ack is sampled high at a rising edge; that valid deasserts on that edge.
REQ-017 SHALL ignore acks while the matching valid is low.
REQ-018 SHALL, on the edge where the last outstanding valid deasserts, assert done and enter DONE; done is a one-cycle pulse; DONE returns to IDLE unconditionally.
REQ-019 SHALL, if inputs_valid=1 with no destination selected, go directly to DONE on the next edge (done pulse, no valids).
REQ-020 SHALL ignore inputs_valid and input changes in WAIT_ACK and DONE; a new transaction is accepted only from IDLE.
REQ-021 SHALL give acks for multiple destinations in any order or simultaneously, with the same result.

Reset
REQ-022 SHALL, while reset=1 at a rising edge, clear all valids, done, data and addresses to 0 and enter IDLE, including mid-transaction (pending writes dropped).
REQ-023 SHALL hold all outputs at 0 for as long as reset stays asserted.

Configuration
REQ-024 SHALL, with macro ALU_MUL_EN defined, implement MUL as the low 32 bits of input_A*input_B.
REQ-025 SHALL, without ALU_MUL_EN, treat MUL as reserved (result 0) and synthesise no multiplier.

Verification
REQ-026 SHALL cover: reset held 3 cycles -> all valids 0, done 0.
REQ-027 SHALL cover: ADD 1+1, reg_out=1, reg_addr=5, inputs_valid=1 -> reg_wr_data_valid=1, reg_wr_data=2, reg_wr_addr=5, done=0; reg_wr_ack=1 -> valid 0, done=1 for one cycle.
REQ-028 SHALL cover: ADD 1+1, mem_out=1, mem_addr=7 -> mem_wr_data_valid=1, mem_wr_data=2, mem_wr_addr=7; mem_wr_ack -> valid 0, done pulse.
REQ-029 SHALL cover: ADD 1+1, pc_jump=1 -> pc_branch_data_valid=1, pc_branch_data=2, other valids 0; pc_branch_data_ack -> done pulse.
REQ-030 SHALL cover: reg_out=mem_out=1 with SUB 5-7 -> both valids, data 0xFFFFFFFE; acks on different cycles -> done only after the second ack.
REQ-031 SHALL cover: reset asserted during WAIT_ACK -> valids clear next edge, no done; SRA 0x80000000 by 4 -> 0xF8000000; MUL 3*4 -> 12 with ALU_MUL_EN, 0 without.
